// File: rtl/reg_dump_unit.sv
// Streams regfile entries FIRST_REG..LAST_REG as beats; first beat 2 cycles after start, max one beat per 2 cycles.
// out_ready low holds the beat stable; `REG_DUMP_CHECKSUM_EN appends an XOR checksum beat.
module reg_dump_unit #(
   parameter int FIRST_REG = 0,
   parameter int LAST_REG  = 31
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   output logic [4:0]  rd_addr,
   input  logic [31:0] rd_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data,
   output logic [4:0]  out_index,
   output logic        out_last,
   output logic        busy,
   output logic        done
);

   localparam logic [4:0] FIRST_IDX = 5'(FIRST_REG);
   localparam logic [4:0] LAST_IDX  = 5'(LAST_REG);

   typedef enum logic [2:0] {
      S_IDLE,
      S_READ,
      S_SEND,
`ifdef REG_DUMP_CHECKSUM_EN
      S_CSUM,
`endif
      S_DONE
   } state_t;

   state_t      state_q;
   logic [4:0]  idx_q;
   logic [4:0]  idx_d;
   logic [4:0]  rd_addr_q;
   logic        out_valid_q;
   logic [31:0] out_data_q;
   logic [4:0]  out_index_q;
   logic        out_last_q;
   logic        busy_q;
   logic        done_q;
`ifdef REG_DUMP_CHECKSUM_EN
   logic [31:0] csum_q;
   logic [31:0] csum_d;

   // Accumulator including the beat being accepted this cycle.
   assign csum_d = csum_q ^ out_data_q;
`endif

   assign idx_d = idx_q + 5'd1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         rd_addr_q   <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_index_q <= '0;
         out_last_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
`ifdef REG_DUMP_CHECKSUM_EN
         csum_q      <= '0;
`endif
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  idx_q     <= FIRST_IDX;
                  rd_addr_q <= FIRST_IDX;
                  busy_q    <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
                  csum_q    <= '0;
`endif
                  state_q   <= S_READ;
               end
            end
            S_READ: begin
               out_data_q  <= rd_data;
               out_index_q <= idx_q;
               out_valid_q <= 1'b1;
`ifdef REG_DUMP_CHECKSUM_EN
               out_last_q  <= 1'b0;
`else
               out_last_q  <= (idx_q == LAST_IDX);
`endif
               state_q     <= S_SEND;
            end
            S_SEND: begin
               if (out_ready) begin
`ifdef REG_DUMP_CHECKSUM_EN
                  csum_q <= csum_d;
`endif
                  if (idx_q != LAST_IDX) begin
                     out_valid_q <= 1'b0;
                     idx_q       <= idx_d;
                     rd_addr_q   <= idx_d;
                     state_q     <= S_READ;
                  end else begin
                     idx_q       <= '0;
                     rd_addr_q   <= '0;
`ifdef REG_DUMP_CHECKSUM_EN
                     out_valid_q <= 1'b1;
                     out_data_q  <= csum_d;
                     out_index_q <= '0;
                     out_last_q  <= 1'b1;
                     state_q     <= S_CSUM;
`else
                     out_valid_q <= 1'b0;
                     out_data_q  <= '0;
                     out_index_q <= '0;
                     out_last_q  <= 1'b0;
                     done_q      <= 1'b1;
                     state_q     <= S_DONE;
`endif
                  end
               end
            end
`ifdef REG_DUMP_CHECKSUM_EN
            S_CSUM: begin
               if (out_ready) begin
                  out_valid_q <= 1'b0;
                  out_data_q  <= '0;
                  out_last_q  <= 1'b0;
                  done_q      <= 1'b1;
                  state_q     <= S_DONE;
               end
            end
`endif
            S_DONE: begin
               // start is deliberately ignored here; a new dump is only taken from IDLE.
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign rd_addr   = rd_addr_q;
   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_index = out_index_q;
   assign out_last  = out_last_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_reg_dump_unit.sv
// Scoreboard bench: a model turns each dump request into the expected beat list; a monitor checks accepted beats.
module tb_reg_dump_unit;

`ifdef REG_DUMP_CHECKSUM_EN
   localparam bit CSUM_EN = 1'b1;
`else
   localparam bit CSUM_EN = 1'b0;
`endif

   typedef struct {
      logic [31:0] data;
      logic [4:0]  idx;
      logic        last;
   } beat_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic        out_ready = 1'b1;
   logic [4:0]  rd_addr;
   logic [31:0] rd_data;
   logic        out_valid;
   logic [31:0] out_data;
   logic [4:0]  out_index;
   logic        out_last;
   logic        busy;
   logic        done;

   logic        start5 = 1'b0;
   logic        ready5 = 1'b1;
   logic [4:0]  rd_addr5;
   logic [31:0] rd_data5;
   logic        valid5;
   logic [31:0] data5;
   logic [4:0]  idx5;
   logic        last5;
   logic        busy5;
   logic        done5;

   logic [31:0] regs [32];
   beat_t       exp_q [$];
   int          n_chk = 0;
   int          n_fail = 0;
   int          n_done = 0;
   int          exp_done = 0;

   assign rd_data  = regs[rd_addr];
   assign rd_data5 = regs[rd_addr5];

   always #5 clk = ~clk;

   reg_dump_unit dut (
      .clk(clk), .reset(reset), .start(start), .rd_addr(rd_addr), .rd_data(rd_data),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_index(out_index),
      .out_last(out_last), .busy(busy), .done(done)
   );

   reg_dump_unit #(.FIRST_REG(5), .LAST_REG(5)) dut5 (
      .clk(clk), .reset(reset), .start(start5), .rd_addr(rd_addr5), .rd_data(rd_data5),
      .out_valid(valid5), .out_ready(ready5), .out_data(data5), .out_index(idx5),
      .out_last(last5), .busy(busy5), .done(done5)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a dump is the listed registers in order, optionally followed by their XOR.
   task automatic push_dump(input int first, input int last);
      logic [31:0] x;
      beat_t b;
      x = '0;
      for (int k = first; k <= last; k++) begin
         b.data = regs[k];
         b.idx  = 5'(k);
         b.last = (k == last) && !CSUM_EN;
         x ^= regs[k];
         exp_q.push_back(b);
      end
      if (CSUM_EN) begin
         b.data = x;
         b.idx  = '0;
         b.last = 1'b1;
         exp_q.push_back(b);
      end
      exp_done++;
   endtask

   task automatic start_pulse();
      @(posedge clk); #1;
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int bound, input bit rnd);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < bound; i++) begin
         @(negedge clk);
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (rnd) begin
            @(posedge clk); #1;
            out_ready = 1'($urandom_range(0, 1));
         end
      end
      chk("done_within_bound", 32'(ok), 32'd1);
   endtask

   // Monitor: hold rules, beat gap, scoreboard pop, done pulse shape.
   logic        p_vld = 1'b0, p_rdy = 1'b0, p_last = 1'b0, p_done = 1'b0;
   logic [31:0] p_data = '0;
   logic [4:0]  p_idx = '0;

   always @(negedge clk) begin
      if (reset) begin
         p_vld  = 1'b0;
         p_rdy  = 1'b0;
         p_done = 1'b0;
      end else begin
         if (p_vld && p_rdy && !(CSUM_EN && p_idx == 5'd31))
            chk("valid_low_after_beat", 32'(out_valid), 32'd0);
         if (p_vld && !p_rdy) begin
            chk("hold_valid", 32'(out_valid), 32'd1);
            chk("hold_data", out_data, p_data);
            chk("hold_index", 32'(out_index), 32'(p_idx));
            chk("hold_last", 32'(out_last), 32'(p_last));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat_index", 32'(out_index), 32'h0000_00ff);
            end else begin
               beat_t e;
               e = exp_q.pop_front();
               chk("beat_data", out_data, e.data);
               chk("beat_index", 32'(out_index), 32'(e.idx));
               chk("beat_last", 32'(out_last), 32'(e.last));
            end
         end
         if (done) begin
            n_done++;
            chk("busy_during_done", 32'(busy), 32'd1);
            chk("done_single_cycle", 32'(p_done), 32'd0);
         end
         p_vld  = out_valid;
         p_rdy  = out_ready;
         p_data = out_data;
         p_idx  = out_index;
         p_last = out_last;
         p_done = done;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int beats;
      for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h0101_0101;

      // Reset values
      #12;
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_last", 32'(out_last), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_out_data", out_data, 32'd0);
      chk("rst_out_index", 32'(out_index), 32'd0);
      chk("rst_rd_addr", 32'(rd_addr), 32'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("idle_busy_no_start", 32'(busy), 32'd0);

      // Full default dump with first-beat latency check
      push_dump(0, 31);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      chk("lat_busy_in_read", 32'(busy), 32'd1);
      chk("lat_valid_in_read", 32'(out_valid), 32'd0);
      chk("lat_rd_addr_first", 32'(rd_addr), 32'd0);
      @(posedge clk); #1;
      chk("lat_first_valid", 32'(out_valid), 32'd1);
      chk("lat_first_index", 32'(out_index), 32'd0);
      wait_done(200, 1'b0);
      @(negedge clk);
      chk("idle_rd_addr_after_done", 32'(rd_addr), 32'd0);

      // Backpressure on beat 3 for five cycles
      push_dump(0, 31);
      start_pulse();
      for (int i = 0; i < 50; i++) begin
         @(posedge clk); #1;
         if (rd_addr == 5'd3 && !out_valid) break;
      end
      out_ready = 1'b0;
      repeat (5) begin
         @(posedge clk); #1;
         chk("stall_valid", 32'(out_valid), 32'd1);
         chk("stall_index", 32'(out_index), 32'd3);
         chk("stall_data", out_data, 32'h0303_0303);
      end
      out_ready = 1'b1;
      wait_done(200, 1'b0);

      // Random register contents with random backpressure
      for (int r = 0; r < 2; r++) begin
         for (int k = 0; k < 32; k++) regs[k] = $urandom;
         push_dump(0, 31);
         start_pulse();
         wait_done(600, 1'b1);
         out_ready = 1'b1;
      end

      // start held high: one dump per IDLE entry
      for (int k = 0; k < 32; k++) regs[k] = 32'(k);
      regs[31] = 32'hFFFF_FFFF;
      push_dump(0, 31);
      push_dump(0, 31);
      @(posedge clk); #1;
      start = 1'b1;
      wait_done(200, 1'b0);
      @(negedge clk);
      chk("held_start_idle_gap", 32'(busy), 32'd0);
      @(negedge clk);
      chk("held_start_restart", 32'(busy), 32'd1);
      wait_done(200, 1'b0);
      start = 1'b0;
      repeat (4) @(negedge clk);
      chk("held_start_no_third", 32'(busy), 32'd0);
      chk("held_start_queue_empty", 32'(exp_q.size()), 32'd0);

      // Asynchronous reset during beat 10
      for (int k = 0; k < 32; k++) regs[k] = 32'(k) * 32'h0101_0101;
      push_dump(0, 31);
      start_pulse();
      for (int i = 0; i < 100; i++) begin
         @(negedge clk);
         if (out_valid && out_index == 5'd10) break;
      end
      #2;
      reset = 1'b1;
      #1;
      chk("arst_valid", 32'(out_valid), 32'd0);
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_index", 32'(out_index), 32'd0);
      exp_q.delete();
      exp_done--;
      @(posedge clk); #1;
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("post_reset_idle", 32'(busy), 32'd0);
      push_dump(0, 31);
      start_pulse();
      wait_done(200, 1'b0);

      // Single-register instance
      beats = 0;
      start5 = 1'b1;
      @(posedge clk); #1;
      start5 = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (valid5) begin
            beats++;
            if (beats == 1) begin
               chk("single_index", 32'(idx5), 32'd5);
               chk("single_data", data5, regs[5]);
               chk("single_last", 32'(last5), 32'(!CSUM_EN));
            end
         end
         if (done5) break;
      end
      chk("single_beat_count", 32'(beats), 32'(1 + int'(CSUM_EN)));

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      chk("done_pulse_count", 32'(n_done), 32'(exp_done));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
